// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared constants and types for the interrupt request latch that sits in
// front of the 8-input priority encoder.
//   IRQ_N      number of request lines (encoder inputs I0..I7)
//   IRQ_IDXW   width of the encoded index (Y2..Y0)
//   irq_vec_t  one bit per request line
//   irq_idx_t  encoded line index
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_IDXW = 3;

    typedef logic [IRQ_N-1:0]    irq_vec_t;
    typedef logic [IRQ_IDXW-1:0] irq_idx_t;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchroniser for one raw request line plus a history flop, with
// the per-line set-event decode (rising edge or level).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears s1, s2, prev)
//   raw        asynchronous request line
//   edge_mode  1 = set on rising edge of the synchronised line, 0 = level
//   set_evt    set request for the pending bit of this line
// ---------------------------------------------------------------------------
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic edge_mode,
    output logic set_evt
);

    logic s1_reg;
    logic s2_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            s1_reg   <= raw;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
        end
    end

    // edge_mode is used directly so a mode change affects the very next set
    // decision; prev clears with reset, so a line held high through reset
    // release looks like a fresh rising edge.
    assign set_evt = edge_mode ? (s2_reg & ~prev_reg) : s2_reg;

endmodule : irq_sync_edge

// File: rtl/irq_request_latch.sv
// ---------------------------------------------------------------------------
// irq_request_latch
// Captures synchronised request lines into sticky pending bits, masks them
// and presents the result to the priority encoder. The consumer clears one
// pending bit by acknowledging the encoded index.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   irq_in      raw asynchronous request lines
//   edge_sel    per-line mode, 1 = rising-edge capture, 0 = level
//   mask_wr     mask register write strobe
//   mask_wdata  new mask, 1 = line enabled
//   ack         acknowledge strobe
//   ack_idx     index being acknowledged
//   ovf_clr     clear all overflow flags
//   req_out     pending & mask, bit k drives encoder input Ik
//   any_req     OR of req_out
//   pending     raw pending register
//   overflow    sticky per-line overflow flags
// ---------------------------------------------------------------------------
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int N    = IRQ_N,
    parameter int IDXW = IRQ_IDXW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    edge_sel,
    input  logic            mask_wr,
    input  logic [N-1:0]    mask_wdata,
    input  logic            ack,
    input  logic [IDXW-1:0] ack_idx,
    input  logic            ovf_clr,
    output logic [N-1:0]    req_out,
    output logic            any_req,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow
);

    logic [N-1:0] set_evt;
    logic [N-1:0] clr_evt;
    logic [N-1:0] ovf_evt;

    logic [N-1:0] pending_reg;
    logic [N-1:0] pending_next;
    logic [N-1:0] overflow_reg;
    logic [N-1:0] overflow_next;
    logic [N-1:0] mask_reg;
    logic [N-1:0] mask_next;

    for (genvar gi = 0; gi < N; gi++) begin : g_line
        localparam logic [IDXW-1:0] LINE_IDX = IDXW'(gi);

        irq_sync_edge u_sync (
            .clk       (clk),
            .rst       (rst),
            .raw       (irq_in[gi]),
            .edge_mode (edge_sel[gi]),
            .set_evt   (set_evt[gi])
        );

        // Indices with no matching line simply never decode.
        assign clr_evt[gi] = ack & (ack_idx == LINE_IDX);

        // Set has priority over clear so an event arriving with the ack is
        // never lost.
        assign pending_next[gi] = set_evt[gi] | (pending_reg[gi] & ~clr_evt[gi]);

        // A second edge while still pending (and not being acknowledged now)
        // means the consumer missed an event. Level lines re-assert by design
        // and are excluded.
        assign ovf_evt[gi] = edge_sel[gi] & set_evt[gi] & pending_reg[gi] & ~clr_evt[gi];
    end

    // A fresh overflow beats a simultaneous clear.
    assign overflow_next = ovf_evt | (ovf_clr ? '0 : overflow_reg);
    assign mask_next     = mask_wr ? mask_wdata : mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg  <= '0;
            overflow_reg <= '0;
            mask_reg     <= '1;
        end else begin
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            mask_reg     <= mask_next;
        end
    end

    // Outputs are purely registered state; irq_in has no combinational path.
    assign req_out  = pending_reg & mask_reg;
    assign any_req  = |req_out;
    assign pending  = pending_reg;
    assign overflow = overflow_reg;

endmodule : irq_request_latch

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream stage of the 8-input priority encoder (inputs I0..I7, encoded outputs Y2..Y0).
- Synchronises 8 raw request lines and captures each as a sticky pending bit, in edge or level mode per line.
- Applies an enable mask and drives the masked pending vector into the encoder inputs.
- Clears one pending bit when the consumer acknowledges the encoded index.

Parameters:
N, 8, number of request lines (encoder input count)
IDXW, 3, width of acknowledge index (clog2 N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
irq_in  input  N  raw asynchronous request lines
edge_sel  input  N  per-line mode: 1 = rising-edge capture, 0 = level
mask_wr  input  1  write strobe for mask register
mask_wdata  input  N  new mask value, 1 = line enabled
ack  input  1  acknowledge strobe from consumer
ack_idx  input  IDXW  index being acknowledged (encoder Y2..Y0)
ovf_clr  input  1  clear all overflow flags
req_out  output  N  pending & mask; bit k drives encoder input Ik
any_req  output  1  OR of req_out
pending  output  N  raw pending register (unmasked)
overflow  output  N  sticky per-line overflow flags

Behaviour:
- Reset: sync stage 1, sync stage 2 and prev registers = 0; pending = 0; overflow = 0; mask = all ones. Consequently req_out = 0 and any_req = 0.
- Synchroniser: two flops per line, s1 <= irq_in, s2 <= s1. prev <= s2.
- Set event, per line k:
  - edge_sel[k] = 1: set_k = s2[k] & ~prev[k].
  - edge_sel[k] = 0: set_k = s2[k].
- Latency: irq_in high at edge E0 gives s2 high after E1 and pending high after E2. req_out is combinational from pending & mask, so it is visible in the cycle after E2.
- Clear event: clr_k = ack & (ack_idx == k). Any ack_idx >= N is ignored.
- Pending update: pending[k] <= set_k ? 1 : (clr_k ? 0 : pending[k]).
  - Set wins over a simultaneous clear, so no event is lost.
  - A level-mode line still high after ack re-asserts on the next edge.
- Ack of a bit that is not pending has no effect.
- Overflow: ovf_k = edge_sel[k] & set_k & pending[k] & ~clr_k.
  - overflow[k] <= ovf_k ? 1 : (ovf_clr ? 0 : overflow[k]).
  - A new overflow in the same cycle as ovf_clr wins.
  - Level-mode lines never flag overflow.
- Mask:
  - mask <= mask_wdata on mask_wr, taking effect on req_out the cycle after the write edge.
  - Masking never blocks capture. A masked pending bit appears on req_out as soon as the line is unmasked.
- Reset mid-operation: all state clears on the next edge regardless of other inputs. A line held high through reset release is seen as a rising edge and captured at the third edge after release.
- Changing edge_sel takes effect immediately on set logic and does not alter existing pending bits.
- No combinational path from irq_in to any output.

Decomposition:
- Package irq_pkg holds:
  - constants IRQ_N = 8 and IRQ_IDXW = 3
  - typedef irq_vec_t (logic [IRQ_N-1:0])
  - typedef irq_idx_t (logic [IRQ_IDXW-1:0])
- Sub-module irq_sync_edge, generated N times: inputs clk, rst, raw, edge_mode; output set_evt.
  - Contains s1, s2 and prev.
  - Pending, mask and overflow logic stay in the top module.

Test Plan:
- Reset, then irq_in = 8'h4A (all edge mode) held from edge E0:
  - pending = 8'h00 through E1.
  - pending = req_out = 8'h4A after E2; any_req = 1.
- Edge mode, pending = 8'h40: ack = 1, ack_idx = 6 → pending = 8'h00 next cycle. Then ack_idx = 3 with bit 3 clear → pending unchanged.
- Level mode on line 1, irq_in[1] held high: ack idx 1 → pending[1] drops for zero cycles (set wins). Deassert irq_in[1], wait 2 cycles, ack → pending[1] = 0 and stays 0.
- Edge mode line 3 pending:
  - Pulse irq_in[3] low→high again without ack → overflow = 8'h08.
  - ovf_clr → overflow = 8'h00.
  - Overflow coinciding with ovf_clr → overflow stays 8'h08.
- mask_wr with 8'hF0 while pending = 8'h4A → req_out = 8'h40 next cycle. Rewrite mask 8'hFF → req_out = 8'h4A.
- Line 0 edge, irq_in[0] held high, assert rst for 2 cycles mid-operation:
  - All outputs 0 during reset.
  - After release, pending[0] = 1 at the third edge.
- ack with ack_idx = 7 and simultaneous new edge on line 7 while pending[7] = 1 → pending[7] stays 1, overflow[7] stays 0.
